// File: rtl/button_pkg.sv
// Shared constants, channel index type and helpers for the button conditioner.
`timescale 1ns/1ps
package button_pkg;

    localparam int unsigned SYS_CLK_HZ   = 25_000_000;
    localparam int unsigned DEBOUNCE_MS  = 10;
    localparam int unsigned MAX_CHANNELS = 32;
    localparam int unsigned CHAN_IDX_W   = 5;

    typedef logic [CHAN_IDX_W-1:0] chan_idx_t;

    function automatic int unsigned cycles_from_ms(input int unsigned ms);
        return (SYS_CLK_HZ / 1000) * ms;
    endfunction

    // Lowest set bit wins; returns 0 for an all-zero vector.
    function automatic chan_idx_t lowest_set(input logic [MAX_CHANNELS-1:0] v);
        chan_idx_t idx;
        idx = '0;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
            if (v[i]) idx = CHAN_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One input: synchroniser, stable-count debounce, edge pulses.
// Auto-repeat of press is built only when BUTTON_REPEAT_EN is defined.
`timescale 1ns/1ps
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = cycles_from_ms(DEBOUNCE_MS),
    parameter int unsigned SYNC_STAGES   = 2
`ifdef BUTTON_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = 12_500_000,
    parameter int unsigned REPEAT_PERIOD = 2_500_000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic press_c
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   s;
    logic                   rise;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef BUTTON_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_first_q, rpt_first_d;
    logic [RPT_W-1:0] rpt_target;
    logic             rpt_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end

    // First repeat waits REPEAT_DELAY after the flip, later ones REPEAT_PERIOD.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        rpt_fire    = 1'b0;
        rpt_target  = rpt_first_q ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
        if (!level_d || rise) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end else if (rpt_cnt_q == rpt_target) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
            rpt_fire    = 1'b1;
        end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
    end
`else
    logic rpt_fire;
    assign rpt_fire = 1'b0;
`endif

    // Level flips only after STABLE_CYCLES consecutive disagreeing samples.
    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        rise      = 1'b0;
        release_d = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            cnt_d     = '0;
            level_d   = s;
            rise      = s;
            release_d = ~s;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        press_d = rise | rpt_fire;
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign press_c   = press_d;

endmodule

// File: rtl/button_conditioner.sv
// N-channel button/switch conditioner with a registered "last pressed" index.
// Define BUTTON_REPEAT_EN to add hold-to-repeat press pulses.
`timescale 1ns/1ps
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned CHANNELS      = 5,
    parameter int unsigned STABLE_CYCLES = cycles_from_ms(DEBOUNCE_MS),
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned REPEAT_DELAY  = 12_500_000,
    parameter int unsigned REPEAT_PERIOD = 2_500_000,
    localparam int unsigned IDX_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] raw_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [IDX_W-1:0]    last_idx_o,
    output logic                last_valid_o
);

    logic [CHANNELS-1:0] press_c;
    logic [IDX_W-1:0]    last_idx_q, last_idx_d;
    logic                last_valid_q, last_valid_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
`ifdef BUTTON_REPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw_i     (raw_i[g]),
            .level_o   (level_o[g]),
            .press_o   (press_o[g]),
            .release_o (release_o[g]),
            .press_c   (press_c[g])
        );
    end

    // Uses next-cycle press so last_idx lands on the same edge as the pulse.
    always_comb begin
        last_idx_d   = last_idx_q;
        last_valid_d = last_valid_q;
        if (|press_c) begin
            last_idx_d   = IDX_W'(lowest_set(MAX_CHANNELS'(press_c)));
            last_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_idx_q   <= '0;
            last_valid_q <= 1'b0;
        end else begin
            last_idx_q   <= last_idx_d;
            last_valid_q <= last_valid_d;
        end
    end

    assign last_idx_o   = last_idx_q;
    assign last_valid_o = last_valid_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (STABLE=4, SYNC=2, 5 channels, repeat 10/3).
`timescale 1ns/1ps
module tb_button_conditioner;

`ifdef BUTTON_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [4:0] raw;
    logic [4:0] level;
    logic [4:0] press;
    logic [4:0] rel;
    logic [2:0] last_idx;
    logic       last_valid;

    int total = 0;
    int bad   = 0;

    button_conditioner #(
        .CHANNELS      (5),
        .STABLE_CYCLES (4),
        .SYNC_STAGES   (2),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_i        (raw),
        .level_o      (level),
        .press_o      (press),
        .release_o    (rel),
        .last_idx_o   (last_idx),
        .last_valid_o (last_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] pat;
        logic [31:0] exp_p;
        pat   = 8'b0111_0111;
        rst_n = 1'b0;
        raw   = '0;
        step(3);
        check("rst_level", 32'(level), 32'h0);
        check("rst_press", 32'(press), 32'h0);
        check("rst_release", 32'(rel), 32'h0);
        check("rst_last_idx", 32'(last_idx), 32'h0);
        check("rst_last_valid", 32'(last_valid), 32'h0);
        rst_n = 1'b1;
        step(2);

        // Bounce on raw[0]: 3 high, 1 low, 3 high, then low
        for (int i = 0; i < 12; i++) begin
            raw[0] = (i < 8) ? pat[i] : 1'b0;
            step(1);
            check("bounce_level0", 32'(level[0]), 32'h0);
            check("bounce_press", 32'(press), 32'h0);
            check("bounce_release", 32'(rel), 32'h0);
        end

        // Clean press on raw[1]
        raw[1] = 1'b1;
        step(1);
        step(4);
        check("press_early_level", 32'(level), 32'h0);
        check("press_early_press", 32'(press), 32'h0);
        step(1);
        check("press_level", 32'(level), 32'h02);
        check("press_pulse", 32'(press), 32'h02);
        check("press_last_idx", 32'(last_idx), 32'h1);
        check("press_last_valid", 32'(last_valid), 32'h1);
        step(1);
        check("press_one_cycle", 32'(press), 32'h0);
        check("press_level_hold", 32'(level), 32'h02);
        step(10);

        // Release raw[1]
        raw[1] = 1'b0;
        step(1);
        step(4);
        check("rel_early_level", 32'(level), 32'h02);
        check("rel_early_release", 32'(rel), 32'h0);
        step(1);
        check("rel_pulse", 32'(rel), 32'h02);
        check("rel_level", 32'(level), 32'h0);
        check("rel_last_idx", 32'(last_idx), 32'h1);
        step(1);
        check("rel_one_cycle", 32'(rel), 32'h0);

        // Simultaneous press on raw[3] and raw[2]
        raw[3:2] = 2'b11;
        step(1);
        step(4);
        check("sim_early_press", 32'(press), 32'h0);
        step(1);
        check("sim_press", 32'(press), 32'h0C);
        check("sim_level", 32'(level), 32'h0C);
        check("sim_last_idx", 32'(last_idx), 32'h2);
        step(1);
        check("sim_press_clear", 32'(press), 32'h0);
        raw[3:2] = 2'b00;
        step(1);
        step(5);
        check("sim_release", 32'(rel), 32'h0C);
        check("sim_level_low", 32'(level), 32'h0);
        step(3);

        // Reset mid-count on raw[4]
        raw[4] = 1'b1;
        step(2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_level", 32'(level), 32'h0);
        check("mid_rst_press", 32'(press), 32'h0);
        check("mid_rst_last_idx", 32'(last_idx), 32'h0);
        check("mid_rst_last_valid", 32'(last_valid), 32'h0);
        step(3);
        check("mid_rst_level_end", 32'(level), 32'h0);
        rst_n = 1'b1;
        step(1);
        step(4);
        check("post_rst_early_press", 32'(press), 32'h0);
        check("post_rst_early_level", 32'(level), 32'h0);
        step(1);
        check("post_rst_press", 32'(press), 32'h10);
        check("post_rst_level", 32'(level), 32'h10);
        check("post_rst_last_idx", 32'(last_idx), 32'h4);
        check("post_rst_last_valid", 32'(last_valid), 32'h1);
        raw[4] = 1'b0;
        step(12);

        // Hold raw[0]; repeat pulses only when enabled
        raw[0] = 1'b1;
        step(1);
        step(5);
        check("hold_first_press", 32'(press), 32'h01);
        check("hold_last_idx", 32'(last_idx), 32'h0);
        for (int k = 1; k <= 24; k++) begin
            step(1);
            exp_p = (RPT && k >= 10 && ((k - 10) % 3) == 0) ? 32'h01 : 32'h0;
            check($sformatf("hold_press_k%0d", k), 32'(press), exp_p);
        end
        check("hold_level", 32'(level), 32'h01);
        raw[0] = 1'b0;
        step(10);
        check("final_level", 32'(level), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
